// File: rtl/pipeline_rr_scheduler.sv
// Round-robin scheduler feeding a fixed-depth register pipeline; the requester ID
// travels with each word and the whole pipeline stalls under output backpressure.
module pipeline_rr_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic                        flush,
  output logic                        out_valid,
  output logic [DATA_W-1:0]           out_data,
  output logic [ID_W-1:0]             out_id,
  input  logic                        out_ready,
  output logic [$clog2(DEPTH+1)-1:0]  occupancy,
  output logic                        busy
);

  localparam int OCC_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0]  valid_r;
  logic [DATA_W-1:0] data_r [DEPTH];
  logic [ID_W-1:0]   id_r   [DEPTH];
  logic [ID_W-1:0]   ptr_r;

  logic              advance_s;
  logic              found_s;
  logic              accept_s;
  logic [ID_W-1:0]   grant_s;
  logic [ID_W-1:0]   ptr_next_s;
  logic [OCC_W-1:0]  occ_s;
  int                idx_s;

  assign advance_s = !flush && (!valid_r[DEPTH-1] || out_ready);
  // rst gates acceptance so nothing is advertised while the pipeline is held in reset
  assign accept_s  = advance_s && found_s && !rst;

  // round-robin search starting at ptr, wrapping modulo NUM_REQ
  always_comb begin
    grant_s = '0;
    found_s = 1'b0;
    idx_s   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_s = (int'(ptr_r) + k) % NUM_REQ;
      if (!found_s && req_valid[idx_s]) begin
        found_s = 1'b1;
        grant_s = ID_W'(idx_s);
      end else begin
        found_s = found_s;
      end
    end
  end

  // one-hot ready toward the granted requester only when the handshake can complete
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = accept_s && (grant_s == ID_W'(i));
    end
  end

  // pointer moves one past the granted requester, wrapping at NUM_REQ-1
  always_comb begin
    if (grant_s == ID_W'(NUM_REQ - 1)) begin
      ptr_next_s = '0;
    end else begin
      ptr_next_s = grant_s + ID_W'(1);
    end
  end

  // pipeline stages and round-robin pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r <= '0;
      ptr_r   <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        data_r[k] <= '0;
        id_r[k]   <= '0;
      end
    end else if (flush) begin
      valid_r <= '0;
    end else if (advance_s) begin
      for (int k = 1; k < DEPTH; k++) begin
        valid_r[k] <= valid_r[k-1];
        data_r[k]  <= data_r[k-1];
        id_r[k]    <= id_r[k-1];
      end
      valid_r[0] <= accept_s;
      if (accept_s) begin
        data_r[0] <= req_data[grant_s*DATA_W +: DATA_W];
        id_r[0]   <= grant_s;
        ptr_r     <= ptr_next_s;
      end else begin
        data_r[0] <= data_r[0];
      end
    end else begin
      valid_r <= valid_r;
    end
  end

  // population count of stage valids
  always_comb begin
    occ_s = '0;
    for (int k = 0; k < DEPTH; k++) begin
      occ_s = occ_s + OCC_W'(valid_r[k]);
    end
  end

  assign occupancy = occ_s;
  assign busy      = |valid_r;
  assign out_valid = valid_r[DEPTH-1];
  assign out_data  = data_r[DEPTH-1];
  assign out_id    = id_r[DEPTH-1];

endmodule

// File: doc/pipeline_rr_scheduler.md
# pipeline_rr_scheduler

Round-robin scheduler that shares a fixed-depth register pipeline between several requesters. Each cycle it picks one valid requester, loads that requester's word into stage 0, and carries the requester ID alongside the data to the output. It stalls the whole pipeline under output backpressure and supports a synchronous flush. It sits between N producer ports and a single consumer in front of the staged datapath.

## Interface
- NUM_REQ, 4, number of requesters (2..16)
- DATA_W, 32, data width per word
- DEPTH, 4, pipeline stages (1..8)
- ID_W, $clog2(NUM_REQ), width of requester ID
- clk  input  1  clock; all state updates on its rising edge
- rst  input  1  asynchronous, active-high reset
- req_valid  input  NUM_REQ  per-requester word available
- req_data  input  NUM_REQ*DATA_W  requester i occupies bits [i*DATA_W +: DATA_W]
- req_ready  output  NUM_REQ  one-hot or zero; word from requester i is accepted when req_valid[i] && req_ready[i]
- flush  input  1  discard all in-flight words
- out_valid  output  1  stage DEPTH-1 holds a word
- out_data  output  DATA_W  word in stage DEPTH-1
- out_id  output  ID_W  requester index of out_data
- out_ready  input  1  consumer accepts word
- occupancy  output  $clog2(DEPTH+1)  count of valid stages
- busy  output  1  occupancy != 0

## Operation
- State: per-stage valid/data/id registers; round-robin pointer ptr (ID_W bits).
- advance = !flush && (!out_valid || out_ready). This is a global enable: all stages shift together, and there is no bubble collapse.
- Grant: first i with req_valid[i], searching ptr, ptr+1, … modulo NUM_REQ. req_ready[grant] = advance; all other req_ready bits are 0. If no request is valid, req_ready = 0 and a bubble (valid=0) enters stage 0 on advance.
- On an accepted handshake, ptr <= grant+1 (wraps NUM_REQ-1 -> 0). Without a handshake, ptr holds.
- On advance: stage[k] <= stage[k-1] for k ≥ 1. Stage 0 <= {1, req_data[grant], grant} on a handshake, else valid=0 (data/id hold).
- On stall (!advance and !flush): all stage registers hold. out_valid/out_data/out_id are stable until out_ready.
- flush: all stage valids clear at the next edge. No acceptance occurs that cycle (req_ready=0). ptr and data registers hold. If out_valid && out_ready in the flush cycle, that output transfer counts as completed.
- occupancy = popcount of stage valids; busy = |stage valids. Both are combinational from registers.
- Reset: all stage valids 0, data 0, ids 0, ptr 0. Therefore out_valid=0, out_data=0, out_id=0, occupancy=0, busy=0, req_ready=0 while rst is asserted. Reset asserted mid-stream drops all in-flight words immediately (asynchronous).

## Timing
- Word accepted at edge t appears on out_* after edge t+DEPTH-1, i.e. DEPTH cycles of latency when never stalled.
- Throughput: one word per cycle when out_ready stays high.
- req_ready depends combinationally on req_valid, out_valid, out_ready, and flush. There are no combinational paths from req_data.
- Each stall cycle adds exactly one cycle of latency to every in-flight word.
- Simultaneous flush and rst: rst dominates.

## Test plan
- Single requester streaming: NUM_REQ=4, DEPTH=4, out_ready=1, req_valid=4'b0010 with data 0xA0..0xA7 on consecutive cycles. Required: first out_valid 4 cycles after the first accept; out_data sequence 0xA0..0xA7; out_id=1 throughout; occupancy rises to 4.
- Round-robin fairness: req_valid=4'b1111 held for 8 cycles, ptr=0 after reset. Required: grant order 0,1,2,3,0,1,2,3; out_id emerges in the same order.
- Backpressure: pipeline full with 0x10,0x11,0x12,0x13, out_ready=0 for 3 cycles. Required: out_data stays 0x10, req_ready=0, occupancy=4; after out_ready=1 the data resumes 0x11,0x12,0x13 with no loss or duplication.
- Skip and wrap: ptr=3, req_valid=4'b0101. Required: grant 0, then ptr=1, next grant 2, then ptr=3, next grant 0.
- Flush mid-stream: 3 words in flight, flush=1 for one cycle while req_valid=4'b0001. Required: req_ready=0 during the flush; next cycle occupancy=0 and out_valid=0; ptr unchanged; the following accept starts normally with latency 4.
- Async reset mid-operation: assert rst between edges with occupancy=3. Required: out_valid=0, occupancy=0, out_data=0 immediately; after release, the first grant goes to requester 0.
